insn_loader: RTL and testbench
==============================

INSN_LOADER -- requirements
Module: insn_loader

Interface
REQ-001 Parameter MAGIC, default 8'h55, frame start byte.
REQ-002 Parameter LOAD_BASE, default 16'h0000, byte address of the first instruction word.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rx_data  input  8  received byte.
REQ-006 rx_valid  input  1  rx_data is valid.
REQ-007 rx_ready  output  1  loader accepts the byte; a transfer occurs when rx_valid & rx_ready are high at a clock edge.
REQ-008 mem_addr  output  16  instruction memory byte address; always even.
REQ-009 mem_wdata  output  16  instruction word to write.
REQ-010 mem_we  output  1  one-cycle write strobe.
REQ-011 mem_busy  input  1  memory cannot accept a write this cycle.
REQ-012 cpu_hold  output  1  holds the CPU while a frame is loading.
REQ-013 done  output  1  one-cycle pulse when a frame loads with a correct checksum.
REQ-014 err  output  1  sticky checksum-error flag.

Function
REQ-015 Frame format SHALL be: MAGIC, count_lo, count_hi, then N = {count_hi,count_lo} words as 2N bytes (low byte first), then a checksum byte.
REQ-016 The checksum SHALL be the 8-bit modulo-256 sum of the 2N data bytes; the MAGIC and count bytes are excluded.
REQ-017 States SHALL be IDLE, CNT_LO, CNT_HI, DATA_LO, DATA_HI, WRITE, CSUM.
REQ-018 IDLE: rx_ready=1; a non-MAGIC byte SHALL be consumed and discarded; a MAGIC byte -> CNT_LO, clear err, clear the sum, set the address to LOAD_BASE, and set cpu_hold.
REQ-019 CNT_LO -> CNT_HI on transfer.
REQ-020 CNT_HI -> DATA_LO on transfer if N!=0; if N==0 -> CSUM.
REQ-021 DATA_LO: latch the low byte -> DATA_HI.
REQ-022 DATA_HI: latch the high byte -> WRITE; each data byte SHALL be added to the sum in the cycle it is transferred.
REQ-023 WRITE: rx_ready=0; mem_we SHALL assert for exactly one cycle, in the first cycle with mem_busy=0, with the assembled word on mem_wdata and the current address on mem_addr.
REQ-024 After the WRITE strobe, the address SHALL increment by 2 (wrapping modulo 2^16) and the remaining count SHALL decrement; next state is DATA_LO if words remain, else CSUM.
REQ-025 mem_addr and mem_wdata SHALL be stable throughout the WRITE state.
REQ-026 CSUM: on transfer, if the byte equals the sum, pulse done for one cycle; otherwise set err. Either case -> IDLE and clear cpu_hold in the same edge.
REQ-027 rx_ready SHALL be 1 in every state except WRITE; it SHALL not depend combinationally on rx_valid.
REQ-028 A MAGIC byte received inside a frame SHALL be treated as ordinary data; there is no resynchronisation mid-frame.
REQ-029 N=65535 SHALL be supported; the address wraps without error.
REQ-030 mem_we and done SHALL never assert in the same cycle.

Reset
REQ-031 While rst_n=0, the following SHALL hold immediately (asynchronously): state=IDLE, rx_ready=1, mem_we=0, mem_addr=LOAD_BASE, mem_wdata=0, cpu_hold=0, done=0, err=0, internal sum and count=0.
REQ-032 Reset mid-frame SHALL abandon the frame with no further write.
REQ-033 A write pending under mem_busy when reset asserts SHALL be dropped.

Verification
REQ-034 Bytes 55 02 00 11 22 33 44 AA, mem_busy=0 -> writes 16'h2211@0000, 16'h4433@0002; done pulse; err=0; cpu_hold high from byte 2 through the CSUM edge.
REQ-035 Same frame with checksum 00 -> both words still written; err=1 sticky, no done; the next 55 clears err.
REQ-036 Bytes 55 00 00 00 -> no mem_we; done pulses.
REQ-037 mem_busy held high 5 cycles during WRITE -> rx_ready=0, address and data stable, a single mem_we in the cycle after mem_busy falls.
REQ-038 Bytes 12 34 55 01 00 55 00 55 -> leading bytes discarded; word 16'h0055@0000 written; done pulses.
REQ-039 rst_n pulsed low after the first data byte of a 3-word frame -> outputs at reset values, no write; a following valid frame loads from LOAD_BASE.

Source files
------------

// File: rtl/insn_loader.sv
// insn_loader: receives a framed instruction image over a byte stream and
// writes it into instruction memory as 16-bit words while holding the CPU.
//
// Frame: MAGIC, count_lo, count_hi, 2*N data bytes (low byte of each word
// first), checksum byte (mod-256 sum of the data bytes only).
//
// Handshake: a byte moves when rx_valid and rx_ready are both high at a
// rising clk edge. rx_ready is a function of state only (low in WRITE).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   rx_data/rx_valid   incoming byte stream
//   rx_ready           loader can accept a byte this cycle
//   mem_addr           even byte address of the word being written
//   mem_wdata          word being written
//   mem_we             single-cycle write strobe (first non-busy WRITE cycle)
//   mem_busy           memory stall; holds the loader in WRITE
//   cpu_hold           high from the MAGIC edge to the checksum edge
//   done               one-cycle pulse after a frame with a good checksum
//   err                sticky checksum error, cleared by the next MAGIC
//   dbg_state          current FSM state, for observation only
module insn_loader #(
    parameter logic [7:0]  MAGIC     = 8'h55,
    parameter logic [15:0] LOAD_BASE = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic        mem_busy,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CNT_LO  = 3'd1;
    localparam logic [2:0] CNT_HI  = 3'd2;
    localparam logic [2:0] DATA_LO = 3'd3;
    localparam logic [2:0] DATA_HI = 3'd4;
    localparam logic [2:0] WRITE   = 3'd5;
    localparam logic [2:0] CSUM    = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  sum_q, sum_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        xfer;
    logic [15:0] new_count;

    assign rx_ready  = (state_q != WRITE);
    assign xfer      = rx_valid & rx_ready;
    // Strobe is combinational on mem_busy so it lands in the first free
    // cycle; the same edge leaves WRITE, so it can only last one cycle.
    assign mem_we    = (state_q == WRITE) & ~mem_busy;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_hold  = hold_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;
    assign new_count = {rx_data, count_q[7:0]};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        sum_d   = sum_q;
        hold_d  = hold_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Non-MAGIC bytes are consumed and dropped.
                if (xfer && rx_data == MAGIC) begin
                    state_d = CNT_LO;
                    err_d   = 1'b0;
                    sum_d   = 8'h00;
                    addr_d  = LOAD_BASE;
                    hold_d  = 1'b1;
                end
            end
            CNT_LO: begin
                if (xfer) begin
                    count_d = {count_q[15:8], rx_data};
                    state_d = CNT_HI;
                end
            end
            CNT_HI: begin
                if (xfer) begin
                    count_d = new_count;
                    state_d = (new_count != 16'h0000) ? DATA_LO : CSUM;
                end
            end
            DATA_LO: begin
                if (xfer) begin
                    wdata_d = {wdata_q[15:8], rx_data};
                    sum_d   = sum_q + rx_data;
                    state_d = DATA_HI;
                end
            end
            DATA_HI: begin
                if (xfer) begin
                    wdata_d = {rx_data, wdata_q[7:0]};
                    sum_d   = sum_q + rx_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!mem_busy) begin
                    addr_d  = addr_q + 16'd2;
                    count_d = count_q - 16'd1;
                    state_d = (count_q == 16'd1) ? CSUM : DATA_LO;
                end
            end
            CSUM: begin
                if (xfer) begin
                    if (rx_data == sum_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    hold_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= LOAD_BASE;
            wdata_q <= 16'h0000;
            count_q <= 16'h0000;
            sum_q   <= 8'h00;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_insn_loader.sv
module tb_insn_loader;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CNT_LO  = 3'd1;
    localparam logic [2:0] S_CNT_HI  = 3'd2;
    localparam logic [2:0] S_DATA_LO = 3'd3;
    localparam logic [2:0] S_DATA_HI = 3'd4;
    localparam logic [2:0] S_WRITE   = 3'd5;
    localparam logic [2:0] S_CSUM    = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_busy = 1'b0;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [2:0]  dbg_state;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic [7:0] b;
        logic [2:0] st;
        logic       hold;
        logic       dn;
    } vec_t;

    vec_t tbl_a[8];
    vec_t tbl_b[8];

    insn_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_busy  (mem_busy),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that moved the byte.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            check("rx_ready_timeout", 32'(rx_ready), 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        send_byte(v.b);
        check({name, "_state"}, 32'(dbg_state), 32'(v.st));
        check({name, "_hold"}, 32'(cpu_hold), 32'(v.hold));
        check({name, "_done"}, 32'(done), 32'(v.dn));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ready"}, 32'(rx_ready), 32'd1);
        check({name, "_we"}, 32'(mem_we), 32'd0);
        check({name, "_addr"}, 32'(mem_addr), 32'h0000);
        check({name, "_wdata"}, 32'(mem_wdata), 32'h0000);
        check({name, "_hold"}, 32'(cpu_hold), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_err"}, 32'(err), 32'd0);
        check({name, "_state"}, 32'(dbg_state), 32'(S_IDLE));
    endtask

    // ---------------- write / done monitor (scoreboard) ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                wr_cnt++;
                check("we_done_exclusive", 32'(done), 32'd0);
                check("write_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check("write_addr_data", {mem_addr, mem_wdata}, exp_q.pop_front());
                end
            end
            if (done) done_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int wr_snap;
        tbl_a[0] = '{8'h55, S_CNT_LO,  1'b1, 1'b0};
        tbl_a[1] = '{8'h02, S_CNT_HI,  1'b1, 1'b0};
        tbl_a[2] = '{8'h00, S_DATA_LO, 1'b1, 1'b0};
        tbl_a[3] = '{8'h11, S_DATA_HI, 1'b1, 1'b0};
        tbl_a[4] = '{8'h22, S_WRITE,   1'b1, 1'b0};
        tbl_a[5] = '{8'h33, S_DATA_HI, 1'b1, 1'b0};
        tbl_a[6] = '{8'h44, S_WRITE,   1'b1, 1'b0};
        tbl_a[7] = '{8'hAA, S_IDLE,    1'b0, 1'b1};

        tbl_b[0] = '{8'h12, S_IDLE,    1'b0, 1'b0};
        tbl_b[1] = '{8'h34, S_IDLE,    1'b0, 1'b0};
        tbl_b[2] = '{8'h55, S_CNT_LO,  1'b1, 1'b0};
        tbl_b[3] = '{8'h01, S_CNT_HI,  1'b1, 1'b0};
        tbl_b[4] = '{8'h00, S_DATA_LO, 1'b1, 1'b0};
        tbl_b[5] = '{8'h55, S_DATA_HI, 1'b1, 1'b0};
        tbl_b[6] = '{8'h00, S_WRITE,   1'b1, 1'b0};
        tbl_b[7] = '{8'h55, S_IDLE,    1'b0, 1'b1};

        // reset values while held in reset
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        cycles(1);

        // two-word frame, good checksum
        exp_q.push_back({16'h0000, 16'h2211});
        exp_q.push_back({16'h0002, 16'h4433});
        for (int i = 0; i < 8; i++) run_vec("good_frame", tbl_a[i]);
        check("good_err", 32'(err), 32'd0);
        cycles(1);
        check("done_one_cycle", 32'(done), 32'd0);

        // same frame, bad checksum: words written, err sticky, no done
        exp_q.push_back({16'h0000, 16'h2211});
        exp_q.push_back({16'h0002, 16'h4433});
        for (int i = 0; i < 7; i++) send_byte(tbl_a[i].b);
        send_byte(8'h00);
        check("bad_err", 32'(err), 32'd1);
        check("bad_done", 32'(done), 32'd0);
        check("bad_hold", 32'(cpu_hold), 32'd0);
        cycles(3);
        check("bad_err_sticky", 32'(err), 32'd1);
        send_byte(8'h55);
        check("magic_clears_err", 32'(err), 32'd0);

        // zero-length frame: no write, done pulses
        wr_snap = wr_cnt;
        send_byte(8'h00);
        send_byte(8'h00);
        check("zero_len_state", 32'(dbg_state), 32'(S_CSUM));
        send_byte(8'h00);
        check("zero_len_done", 32'(done), 32'd1);
        check("zero_len_no_write", 32'(wr_cnt), 32'(wr_snap));

        // leading junk discarded, MAGIC inside the frame is data
        exp_q.push_back({16'h0000, 16'h0055});
        for (int i = 0; i < 8; i++) run_vec("junk_frame", tbl_b[i]);

        // write stalled by mem_busy for 5 cycles
        exp_q.push_back({16'h0000, 16'hCDAB});
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAB);
        mem_busy = 1'b1;
        wr_snap = wr_cnt;
        send_byte(8'hCD);
        for (int i = 0; i < 5; i++) begin
            check("busy_ready", 32'(rx_ready), 32'd0);
            check("busy_addr", 32'(mem_addr), 32'h0000);
            check("busy_wdata", 32'(mem_wdata), 32'hCDAB);
            check("busy_we", 32'(mem_we), 32'd0);
            cycles(1);
        end
        check("busy_state", 32'(dbg_state), 32'(S_WRITE));
        check("busy_no_write", 32'(wr_cnt), 32'(wr_snap));
        mem_busy = 1'b0;
        #1;
        check("busy_release_we", 32'(mem_we), 32'd1);
        cycles(1);
        check("busy_single_write", 32'(wr_cnt), 32'(wr_snap + 1));
        check("busy_state_after", 32'(dbg_state), 32'(S_CSUM));
        send_byte(8'h78);
        check("busy_done", 32'(done), 32'd1);

        // reset mid-frame after first data byte of a 3-word frame
        wr_snap = wr_cnt;
        send_byte(8'h55);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        cycles(1);
        rst_n = 1'b1;
        cycles(2);
        check("midframe_no_write", 32'(wr_cnt), 32'(wr_snap));
        exp_q.push_back({16'h0000, 16'h1234});
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'h46);
        check("after_reset_done", 32'(done), 32'd1);

        // write pending under mem_busy is dropped by reset
        wr_snap = wr_cnt;
        mem_busy = 1'b1;
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        cycles(2);
        rst_n = 1'b0;
        #1;
        check("busy_reset_we", 32'(mem_we), 32'd0);
        mem_busy = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        cycles(3);
        check("busy_reset_dropped", 32'(wr_cnt), 32'(wr_snap));
        check("busy_reset_state", 32'(dbg_state), 32'(S_IDLE));

        // final tallies
        check("total_writes", 32'(wr_cnt), 32'd7);
        check("total_done", 32'(done_cnt), 32'd5);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
